mem_ctrl: RTL and testbench

Single-port byte-wide RAM sequencer and arbiter shared by the instruction-fetch port (IF) and the load/store port (MEM stage).
- Accepts one multi-byte transaction at a time and issues it to RAM one byte per cycle.
- Assembles or disassembles 32-bit data and pulses a done strobe to the owning requester.
- Sits between the pipeline stages and the top-level RAM/IO pins.

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_byte_asm.sv | 30 +++
 rtl/mem_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-wide RAM sequencer: request codes, length codes,
// FSM state encodings and the owner type.
package mem_ctrl_pkg;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_READ  = 2'b01;
  localparam logic [1:0] ST_WRITE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_t;

  // 2'b10 is not a legal length code; it is treated as a word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_asm.sv
// 4-byte assembly register: clears, loads a whole word, or captures one byte
// at idx; byte_sel exposes the byte at idx for write disassembly.
module mem_byte_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        cap,
  input  logic [1:0]  idx,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic [7:0]  byte_sel
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
    end else if (clr) begin
      word <= '0;
    end else if (load) begin
      word <= load_word;
    end else if (cap) begin
      word[{idx, 3'b000} +: 8] <= din;
    end
  end

  assign byte_sel = word[{idx, 3'b000} +: 8];

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide RAM sequencer shared by instruction fetch and the load/store port.
// Handshake: a requester holds its request until its one-cycle done strobe.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic [1:0]        mem_rw,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [1:0]        fsm_state
);

  logic [1:0]        state;
  owner_t            owner;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        n_q;
  logic [2:0]        icnt;
  logic [2:0]        rcnt;
  logic              issuing;
  logic              rd_valid;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_rdata_q;

  logic        mem_grant;
  logic        if_grant;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_n;
  logic        if_abort;
  logic        asm_clr;
  logic        asm_load;
  logic        asm_cap;
  logic [1:0]  asm_idx;
  logic [31:0] asm_word;
  logic [7:0]  asm_byte;
  logic        unused_addr_bits;

  // MEM wins over IF; flush only blocks the IF grant.
  assign mem_grant = (mem_rw == RW_READ) || (mem_rw == RW_WRITE);
  assign if_grant  = !mem_grant && if_req && !flush;
  assign req_write = mem_grant && (mem_rw == RW_WRITE);
  assign req_addr  = mem_grant ? mem_addr : if_addr;
  assign req_n     = mem_grant ? len_bytes(mem_len) : 3'd4;
  assign if_abort  = (owner == OWNER_IF) && (state != ST_IDLE) && flush;

  assign unused_addr_bits = ^req_addr[31:ADDR_W];

  assign asm_clr  = (state == ST_IDLE) && (mem_grant || if_grant) && !req_write;
  assign asm_load = (state == ST_IDLE) && req_write;
  assign asm_cap  = (state == ST_READ) && rd_valid && !if_abort;
  assign asm_idx  = (state == ST_READ) ? rcnt[1:0] : icnt[1:0];

  mem_byte_asm u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .load      (asm_load),
    .load_word (mem_wdata),
    .cap       (asm_cap),
    .idx       (asm_idx),
    .din       (ram_din),
    .word      (asm_word),
    .byte_sel  (asm_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      owner    <= OWNER_IF;
      op_write <= 1'b0;
      addr_q   <= '0;
      n_q      <= '0;
      icnt     <= '0;
      rcnt     <= '0;
      issuing  <= 1'b0;
      rd_valid <= 1'b0;
      ram_a    <= '0;
      ram_dout <= '0;
      ram_wr   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_grant || if_grant) begin
            owner    <= mem_grant ? OWNER_MEM : OWNER_IF;
            op_write <= req_write;
            addr_q   <= req_addr[ADDR_W-1:0];
            n_q      <= req_n;
            ram_a    <= req_addr[ADDR_W-1:0];
            icnt     <= 3'd1;
            rcnt     <= 3'd0;
            rd_valid <= 1'b0;
            if (req_write) begin
              ram_dout <= mem_wdata[7:0];
              ram_wr   <= 1'b1;
              state    <= ST_WRITE;
            end else begin
              issuing <= 1'b1;
              state   <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (if_abort) begin
            issuing  <= 1'b0;
            rd_valid <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            // issuing: an address is on ram_a this cycle, so its data lands next cycle.
            if (issuing) begin
              if (icnt != n_q) begin
                ram_a <= addr_q + ADDR_W'(icnt);
                icnt  <= icnt + 3'd1;
              end else begin
                issuing <= 1'b0;
              end
            end
            rd_valid <= issuing;
            if (rd_valid) begin
              rcnt <= rcnt + 3'd1;
              if (rcnt == n_q - 3'd1) state <= ST_DONE;
            end
          end
        end
        ST_WRITE: begin
          if (icnt != n_q) begin
            ram_a    <= addr_q + ADDR_W'(icnt);
            ram_dout <= asm_byte;
            icnt     <= icnt + 3'd1;
          end else begin
            ram_wr <= 1'b0;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Done cycle forwards the assembled word directly; the holding registers keep it afterwards.
  assign if_done   = (state == ST_DONE) && (owner == OWNER_IF) && !flush;
  assign mem_done  = (state == ST_DONE) && (owner == OWNER_MEM);
  assign if_data   = if_done ? asm_word : if_data_q;
  assign mem_rdata = (mem_done && !op_write) ? asm_word : mem_rdata_q;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (if_done) if_data_q <= asm_word;
      if (mem_done && !op_write) mem_rdata_q <= asm_word;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide RAM model answering one cycle
// after the address.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              if_req = 1'b0;
  logic [31:0]       if_addr = '0;
  logic              if_done;
  logic [31:0]       if_data;
  logic [1:0]        mem_rw = RW_NONE;
  logic [1:0]        mem_len = LEN_BYTE;
  logic [31:0]       mem_addr = '0;
  logic [31:0]       mem_wdata = '0;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic [7:0]        ram_din = '0;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [1:0]        fsm_state;

  logic [7:0] ram [0:(1<<ADDR_W)-1];

  int total = 0;
  int bad = 0;

  logic [ADDR_W-1:0] a_l      [32];
  logic              w_l      [32];
  logic [7:0]        d_l      [32];
  logic              ifd_l    [32];
  logic              memd_l   [32];
  logic [31:0]       ifdata_l [32];
  logic [31:0]       mrdata_l [32];
  logic [1:0]        st_l     [32];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_din <= ram[ram_a];
    if (ram_wr) ram[ram_a] = ram_dout;
  end

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_data   (if_data),
    .mem_rw    (mem_rw),
    .mem_len   (mem_len),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_a     (ram_a),
    .ram_wr    (ram_wr),
    .fsm_state (fsm_state)
  );

  // Called at the start of cycle 0 with the request already driven; logs ncyc cycles.
  task automatic capture(input int ncyc, input int flush_cyc, input int if_drop_cyc);
    for (int c = 0; c < ncyc; c++) begin
      flush = (c == flush_cyc);
      if (c == if_drop_cyc) if_req = 1'b0;
      @(negedge clk);
      a_l[c] = ram_a;   w_l[c] = ram_wr;     d_l[c] = ram_dout;
      ifd_l[c] = if_done; memd_l[c] = mem_done;
      ifdata_l[c] = if_data; mrdata_l[c] = mem_rdata; st_l[c] = fsm_state;
      if (if_done) if_req = 1'b0;
      if (mem_done) mem_rw = RW_NONE;
      @(posedge clk); #1;
    end
    flush = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({ram_wr, ram_a, ram_dout} !== '0) begin
      bad++; $display("FAIL reset_ram_side: got wr=%b a=%h dout=%h want all 0", ram_wr, ram_a, ram_dout);
    end
    total++;
    if ({if_done, mem_done, if_data, mem_rdata} !== '0) begin
      bad++; $display("FAIL reset_req_side: got if_done=%b mem_done=%b if_data=%h mem_rdata=%h want all 0",
                      if_done, mem_done, if_data, mem_rdata);
    end
    total++;
    if (fsm_state !== ST_IDLE) begin
      bad++; $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_IDLE);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_if_read;
    int nd;
    logic [ADDR_W-1:0] exp_a;
    ram[17'h100] = 8'h11; ram[17'h101] = 8'h22; ram[17'h102] = 8'h33; ram[17'h103] = 8'h44;
    if_addr = 32'h100; if_req = 1'b1;
    capture(8, -1, -1);
    for (int k = 0; k < 4; k++) begin
      exp_a = 17'h100 + 17'(k);
      total++;
      if (a_l[k+1] !== exp_a || w_l[k+1] !== 1'b0) begin
        bad++; $display("FAIL if_rd_addr%0d: got a=%h wr=%b want a=%h wr=0", k, a_l[k+1], w_l[k+1], exp_a);
      end
    end
    nd = 0;
    for (int c = 0; c < 8; c++) if (ifd_l[c] === 1'b1 || memd_l[c] === 1'b1) nd++;
    total++;
    if (ifd_l[6] !== 1'b1 || nd != 1) begin
      bad++; $display("FAIL if_rd_done: got done@6=%b strobes=%0d want 1 and 1", ifd_l[6], nd);
    end
    total++;
    if (ifdata_l[6] !== 32'h44332211 || ifdata_l[7] !== 32'h44332211) begin
      bad++; $display("FAIL if_rd_data: got %h/%h want 44332211", ifdata_l[6], ifdata_l[7]);
    end
  endtask

  task automatic test_word_write;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'hD4; exp_d[1] = 8'hC3; exp_d[2] = 8'hB2; exp_d[3] = 8'hA1;
    mem_rw = RW_WRITE; mem_len = LEN_WORD; mem_addr = 32'h200; mem_wdata = 32'hA1B2C3D4;
    capture(7, -1, -1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (w_l[k+1] !== 1'b1 || d_l[k+1] !== exp_d[k] || a_l[k+1] !== 17'h200 + 17'(k)) begin
        bad++; $display("FAIL wr_byte%0d: got wr=%b a=%h d=%h want wr=1 a=%h d=%h",
                        k, w_l[k+1], a_l[k+1], d_l[k+1], 17'h200 + 17'(k), exp_d[k]);
      end
    end
    total++;
    if (w_l[5] !== 1'b0 || memd_l[5] !== 1'b1 || memd_l[4] !== 1'b0) begin
      bad++; $display("FAIL wr_done: got wr@5=%b done@4=%b done@5=%b want 0 0 1", w_l[5], memd_l[4], memd_l[5]);
    end
    total++;
    if ({ram[17'h203], ram[17'h202], ram[17'h201], ram[17'h200]} !== 32'hA1B2C3D4) begin
      bad++; $display("FAIL wr_ram: got %h want a1b2c3d4", {ram[17'h203], ram[17'h202], ram[17'h201], ram[17'h200]});
    end
    mem_rw = RW_READ; mem_len = LEN_WORD; mem_addr = 32'h200;
    capture(8, -1, -1);
    total++;
    if (memd_l[6] !== 1'b1 || mrdata_l[6] !== 32'hA1B2C3D4) begin
      bad++; $display("FAIL wr_readback: got done=%b data=%h want 1 a1b2c3d4", memd_l[6], mrdata_l[6]);
    end
  endtask

  task automatic test_arbitration;
    ram[17'h7] = 8'h80;
    mem_rw = RW_READ; mem_len = LEN_BYTE; mem_addr = 32'h7;
    if_addr = 32'h200; if_req = 1'b1;
    capture(12, -1, -1);
    total++;
    if (a_l[1] !== 17'h7 || memd_l[3] !== 1'b1 || mrdata_l[3] !== 32'h00000080) begin
      bad++; $display("FAIL arb_mem_first: got a=%h done=%b data=%h want 7 1 00000080", a_l[1], memd_l[3], mrdata_l[3]);
    end
    total++;
    if (st_l[5] !== ST_READ || a_l[5] !== 17'h200 || ifd_l[9] !== 1'b0) begin
      bad++; $display("FAIL arb_if_grant: got st@5=%0d a@5=%h done@9=%b want 1 200 0", st_l[5], a_l[5], ifd_l[9]);
    end
    total++;
    if (ifd_l[10] !== 1'b1 || ifdata_l[10] !== 32'hA1B2C3D4) begin
      bad++; $display("FAIL arb_if_done: got done=%b data=%h want 1 a1b2c3d4", ifd_l[10], ifdata_l[10]);
    end
    total++;
    if (mrdata_l[11] !== 32'h00000080) begin
      bad++; $display("FAIL arb_rdata_hold: got %h want 00000080", mrdata_l[11]);
    end
  endtask

  task automatic test_flush;
    int nd;
    ram[17'h40] = 8'hDE; ram[17'h41] = 8'hAD; ram[17'h42] = 8'hBE; ram[17'h43] = 8'hEF;
    if_addr = 32'h100; if_req = 1'b1;
    capture(8, 3, 3);
    nd = 0;
    for (int c = 0; c < 8; c++) if (ifd_l[c] === 1'b1) nd++;
    total++;
    if (st_l[3] !== ST_READ || st_l[4] !== ST_IDLE || nd != 0) begin
      bad++; $display("FAIL flush_abort: got st@3=%0d st@4=%0d if_done count=%0d want 1 0 0", st_l[3], st_l[4], nd);
    end
    total++;
    if (ifdata_l[7] !== 32'hA1B2C3D4) begin
      bad++; $display("FAIL flush_hold: got %h want a1b2c3d4", ifdata_l[7]);
    end
    // Flush in IDLE delays the IF grant by exactly that cycle.
    if_addr = 32'h40; if_req = 1'b1;
    capture(9, 0, -1);
    total++;
    if (ifd_l[6] !== 1'b0 || ifd_l[7] !== 1'b1 || ifdata_l[7] !== 32'hEFBEADDE) begin
      bad++; $display("FAIL flush_idle: got done@6=%b done@7=%b data=%h want 0 1 efbeadde", ifd_l[6], ifd_l[7], ifdata_l[7]);
    end
    mem_rw = RW_READ; mem_len = LEN_BYTE; mem_addr = 32'h41;
    if_addr = 32'h100; if_req = 1'b1;
    capture(12, 0, -1);
    total++;
    if (memd_l[3] !== 1'b1 || mrdata_l[3] !== 32'h000000AD) begin
      bad++; $display("FAIL flush_mem_grant: got done=%b data=%h want 1 000000ad", memd_l[3], mrdata_l[3]);
    end
    total++;
    if (ifd_l[10] !== 1'b1 || ifdata_l[10] !== 32'h44332211) begin
      bad++; $display("FAIL flush_then_if: got done=%b data=%h want 1 44332211", ifd_l[10], ifdata_l[10]);
    end
  endtask

  task automatic test_half_wrap;
    ram[17'h1FFFF] = 8'h5A; ram[17'h0] = 8'hC3;
    mem_rw = RW_READ; mem_len = LEN_HALF; mem_addr = 32'h1FFFF;
    capture(6, -1, -1);
    total++;
    if (a_l[1] !== 17'h1FFFF || a_l[2] !== 17'h00000) begin
      bad++; $display("FAIL half_wrap_addr: got %h,%h want 1ffff,00000", a_l[1], a_l[2]);
    end
    total++;
    if (memd_l[4] !== 1'b1 || memd_l[3] !== 1'b0 || mrdata_l[4] !== 32'h0000C35A) begin
      bad++; $display("FAIL half_wrap_data: got done@3=%b done@4=%b data=%h want 0 1 0000c35a",
                      memd_l[3], memd_l[4], mrdata_l[4]);
    end
    mem_rw = RW_READ; mem_len = 2'b10; mem_addr = 32'h100;
    capture(8, -1, -1);
    total++;
    if (memd_l[5] !== 1'b0 || memd_l[6] !== 1'b1 || mrdata_l[6] !== 32'h44332211) begin
      bad++; $display("FAIL len10_word: got done@5=%b done@6=%b data=%h want 0 1 44332211",
                      memd_l[5], memd_l[6], mrdata_l[6]);
    end
  endtask

  task automatic test_reset_mid_write;
    int nd;
    ram[17'h301] = 8'h77;
    mem_rw = RW_WRITE; mem_len = LEN_WORD; mem_addr = 32'h300; mem_wdata = 32'h01020304;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    mem_rw = RW_NONE;
    #1;
    total++;
    if ({ram_wr, ram_a, ram_dout} !== '0 || fsm_state !== ST_IDLE) begin
      bad++; $display("FAIL rst_mid_ram: got wr=%b a=%h dout=%h st=%0d want all 0", ram_wr, ram_a, ram_dout, fsm_state);
    end
    total++;
    if ({mem_done, mem_rdata, if_data} !== '0) begin
      bad++; $display("FAIL rst_mid_req: got done=%b rdata=%h if_data=%h want all 0", mem_done, mem_rdata, if_data);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    nd = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_done !== 1'b0 || fsm_state !== ST_IDLE) nd++;
    end
    total++;
    if (nd != 0) begin
      bad++; $display("FAIL rst_no_done: got %0d bad idle cycles want 0", nd);
    end
    total++;
    if (ram[17'h301] !== 8'h77) begin
      bad++; $display("FAIL rst_no_write: got %h want 77", ram[17'h301]);
    end
    @(posedge clk); #1;
    mem_rw = RW_READ; mem_len = LEN_BYTE; mem_addr = 32'h300;
    capture(6, -1, -1);
    total++;
    if (memd_l[3] !== 1'b1 || mrdata_l[3] !== 32'h00000004) begin
      bad++; $display("FAIL rst_recover: got done=%b data=%h want 1 00000004", memd_l[3], mrdata_l[3]);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
    test_reset();
    test_if_read();
    test_word_write();
    test_arbitration();
    test_flush();
    test_half_wrap();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
